// File: rtl/writeback_arbiter.sv
// -----------------------------------------------------------------------------
// writeback_arbiter
//
// Shares the single register-file write port between the in-order pipeline
// writeback result and a long-latency execution unit (mul/div) that completes
// out of band. Pipeline writes always win. Long results are buffered in a small
// FIFO and drained into idle write slots. A starvation counter forces a
// one-cycle writeback stall when the buffer has not been drained for
// STARVE_LIMIT consecutive cycles.
//
// Parameters:
//   DEPTH         long-result FIFO entries (power of two, >= 2)
//   STARVE_LIMIT  non-draining cycles with FIFO non-empty before a forced stall
//
// Ports:
//   clk, rst_n                         clock, async active-low reset
//   RegWriteW/WriteAddressW/ResultW    pipeline writeback request
//   LongValid/LongAddress/LongData     long-unit result offer
//   LongReady                          long result accepted this cycle
//   ReadAddr1/2, PendingHit1/2         decode sources vs live buffered results
//   StallW                             pipeline must hold its writeback
//   RegWriteD/WriteAddressD/RegInDataD register-file write port
//
// Optional feature: define WB_ARB_BYPASS_EN to let a long result go straight
// to the write port when the FIFO is empty and the slot is idle.
// -----------------------------------------------------------------------------
module writeback_arbiter #(
  parameter int DEPTH        = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        RegWriteW,
  input  logic [4:0]  WriteAddressW,
  input  logic [31:0] ResultW,
  input  logic        LongValid,
  input  logic [4:0]  LongAddress,
  input  logic [31:0] LongData,
  output logic        LongReady,
  input  logic [4:0]  ReadAddr1,
  input  logic [4:0]  ReadAddr2,
  output logic        PendingHit1,
  output logic        PendingHit2,
  output logic        StallW,
  output logic        RegWriteD,
  output logic [4:0]  WriteAddressD,
  output logic [31:0] RegInDataD
);

  localparam int         AW    = $clog2(DEPTH);
  localparam logic [7:0] LIMIT = 8'(STARVE_LIMIT);

  logic [DEPTH-1:0] live;
  logic [4:0]       addr_mem [DEPTH];
  logic [31:0]      data_mem [DEPTH];
  logic [AW:0]      wptr, rptr;
  logic [AW-1:0]    head, tail;
  logic [7:0]       count;

  logic empty, full, hs, pipe_wr, pop, kill, enq, bypass;

  assign head  = rptr[AW-1:0];
  assign tail  = wptr[AW-1:0];
  assign empty = (wptr == rptr);
  // Extra pointer bit distinguishes full from empty when the indices match.
  assign full  = (wptr[AW] != rptr[AW]) && (tail == head);

  // Computed from the pre-pop state: a slot freed this cycle is offered next cycle.
  assign LongReady = rst_n & ~full;
  assign hs        = LongValid & LongReady;
  // A pipeline write to x0 is an idle slot.
  assign pipe_wr   = RegWriteW && (WriteAddressW != 5'd0);
  // Count only reaches the limit while the FIFO is non-empty, so a forced
  // stall always has a head to drain.
  assign StallW    = (count == LIMIT);

`ifdef WB_ARB_BYPASS_EN
  assign bypass = hs && (LongAddress != 5'd0) && empty && !StallW && !pipe_wr;
`else
  assign bypass = 1'b0;
`endif

  assign enq = hs && (LongAddress != 5'd0) && !bypass;

  // Write-port selection in priority order: forced drain, pipeline, drain, bypass.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path infers a latch.
    RegWriteD     = 1'b0;
    WriteAddressD = WriteAddressW;
    RegInDataD    = ResultW;
    pop           = 1'b0;
    kill          = 1'b0;
    if (rst_n) begin
      if (StallW || (!pipe_wr && !empty)) begin
        if (!empty) begin
          pop           = 1'b1;
          RegWriteD     = live[head];   // a killed head is popped silently
          WriteAddressD = addr_mem[head];
          RegInDataD    = data_mem[head];
        end
      end else if (pipe_wr) begin
        RegWriteD = 1'b1;
        kill      = 1'b1;
      end else if (bypass) begin
        RegWriteD     = 1'b1;
        WriteAddressD = LongAddress;
        RegInDataD    = LongData;
      end
    end
  end

  // Pending hits cover live buffered entries and a result handshaking now.
  always_comb begin
    PendingHit1 = hs && (LongAddress == ReadAddr1);
    PendingHit2 = hs && (LongAddress == ReadAddr2);
    for (int i = 0; i < DEPTH; i++) begin
      if (live[i] && (addr_mem[i] == ReadAddr1)) PendingHit1 = 1'b1;
      if (live[i] && (addr_mem[i] == ReadAddr2)) PendingHit2 = 1'b1;
    end
    if (ReadAddr1 == 5'd0) PendingHit1 = 1'b0;
    if (ReadAddr2 == 5'd0) PendingHit2 = 1'b0;
  end

  // NOTE: payload storage has no reset; validity lives in the reset live bits,
  // so stale addr/data is never observed.
  always_ff @(posedge clk) begin
    if (enq) begin
      addr_mem[tail] <= LongAddress;
      data_mem[tail] <= LongData;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every update sees
  // pre-edge values. Statement order matters for live: pop and kill clear first,
  // then a same-cycle enqueue sets its slot, so the younger result survives.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
      live  <= '0;
    end else begin
      if (pop) begin
        live[head] <= 1'b0;
        rptr       <= rptr + (AW+1)'(1);
      end
      if (kill) begin
        for (int i = 0; i < DEPTH; i++) begin
          if (addr_mem[i] == WriteAddressW) live[i] <= 1'b0;
        end
      end
      if (enq) begin
        live[tail] <= 1'b1;
        wptr       <= wptr + (AW+1)'(1);
      end
      if (empty || pop)        count <= '0;
      else if (count != 8'hFF) count <= count + 8'd1;
    end
  end

endmodule

// File: tb/tb_writeback_arbiter.sv
// -----------------------------------------------------------------------------
// tb_writeback_arbiter
//
// Directed self-checking bench for writeback_arbiter (DEPTH=4, STARVE_LIMIT=8).
// Inputs change 2 time units after a rising edge; outputs are sampled 1 unit
// later, well away from the next edge. Honours WB_ARB_BYPASS_EN for the one
// latency-dependent step.
// -----------------------------------------------------------------------------
module tb_writeback_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        RegWriteW;
  logic [4:0]  WriteAddressW;
  logic [31:0] ResultW;
  logic        LongValid;
  logic [4:0]  LongAddress;
  logic [31:0] LongData;
  logic        LongReady;
  logic [4:0]  ReadAddr1, ReadAddr2;
  logic        PendingHit1, PendingHit2;
  logic        StallW;
  logic        RegWriteD;
  logic [4:0]  WriteAddressD;
  logic [31:0] RegInDataD;

  int total = 0;
  int bad   = 0;

  writeback_arbiter #(.DEPTH(4), .STARVE_LIMIT(8)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .RegWriteW     (RegWriteW),
    .WriteAddressW (WriteAddressW),
    .ResultW       (ResultW),
    .LongValid     (LongValid),
    .LongAddress   (LongAddress),
    .LongData      (LongData),
    .LongReady     (LongReady),
    .ReadAddr1     (ReadAddr1),
    .ReadAddr2     (ReadAddr2),
    .PendingHit1   (PendingHit1),
    .PendingHit2   (PendingHit2),
    .StallW        (StallW),
    .RegWriteD     (RegWriteD),
    .WriteAddressD (WriteAddressD),
    .RegInDataD    (RegInDataD)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic check_port(input string tag, input logic we, input logic [4:0] a,
                            input logic [31:0] d);
    check({tag, ".we"}, 32'(RegWriteD), 32'(we));
    if (we) begin
      check({tag, ".addr"}, 32'(WriteAddressD), 32'(a));
      check({tag, ".data"}, RegInDataD, d);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; RegWriteW = 1'b1; WriteAddressW = 5'd3; ResultW = 32'h33;
    LongValid = 1'b0; LongAddress = '0; LongData = '0;
    ReadAddr1 = '0; ReadAddr2 = '0;
    #3;
    // Reset: write port forced off even with a pipeline request.
    check("rst.ready",  32'(LongReady),   0);
    check("rst.we",     32'(RegWriteD),   0);
    check("rst.stall",  32'(StallW),      0);
    check("rst.hit1",   32'(PendingHit1), 0);
    tick();
    rst_n = 1'b1; RegWriteW = 1'b0; settle();
    check("rel.ready", 32'(LongReady), 1);
    check("rel.we",    32'(RegWriteD), 0);

    // Idle pipeline, single long result to x5.
    LongValid = 1'b1; LongAddress = 5'd5; LongData = 32'h1234; ReadAddr1 = 5'd5;
    settle();
    check("t1.hit_hs", 32'(PendingHit1), 1);
`ifdef WB_ARB_BYPASS_EN
    check_port("t1.byp", 1'b1, 5'd5, 32'h1234);
    tick();
    LongValid = 1'b0; settle();
    check_port("t1.after", 1'b0, 5'd0, 32'h0);
`else
    check_port("t1.n", 1'b0, 5'd0, 32'h0);
    tick();
    LongValid = 1'b0; settle();
    check_port("t1.n1", 1'b1, 5'd5, 32'h1234);
    check("t1.hit_buf", 32'(PendingHit1), 1);
    tick();
    check_port("t1.n2", 1'b0, 5'd0, 32'h0);
    check("t1.hit_gone", 32'(PendingHit1), 0);
`endif
    ReadAddr1 = '0;

    // Starvation: pipeline busy on x1 while four long results fill the FIFO.
    RegWriteW = 1'b1; WriteAddressW = 5'd1; ResultW = 32'h11;
    for (int i = 0; i < 4; i++) begin
      LongValid = 1'b1; LongAddress = 5'(10 + i); LongData = 32'hA0 + 32'(i);
      settle();
      check("t2.ready_fill", 32'(LongReady), 1);
      check_port("t2.pipe", 1'b1, 5'd1, 32'h11);
      tick();
    end
    LongValid = 1'b0; settle();
    check("t2.full", 32'(LongReady), 0);
    for (int i = 0; i < 5; i++) begin
      check("t2.nostall0", 32'(StallW), 0);
      check_port("t2.pipe_starve", 1'b1, 5'd1, 32'h11);
      tick();
    end
    check("t2.stall0", 32'(StallW), 1);
    check_port("t2.drain0", 1'b1, 5'd10, 32'hA0);
    for (int e = 1; e < 4; e++) begin
      for (int i = 0; i < 8; i++) begin
        tick();
        if (e == 1 && i == 0) check("t2.ready_after_pop", 32'(LongReady), 1);
        check("t2.nostall", 32'(StallW), 0);
      end
      tick();
      check("t2.stall", 32'(StallW), 1);
      check_port("t2.drain", 1'b1, 5'(10 + e), 32'hA0 + 32'(e));
    end
    tick();
    check("t2.empty_nostall", 32'(StallW), 0);
    check_port("t2.pipe_end", 1'b1, 5'd1, 32'h11);

    // Kill: buffer x7=AAAA behind a busy pipeline, then pipeline writes x7=BBBB.
    LongValid = 1'b1; LongAddress = 5'd7; LongData = 32'hAAAA; ReadAddr1 = 5'd7;
    settle();
    tick();
    LongValid = 1'b0; WriteAddressW = 5'd7; ResultW = 32'hBBBB; settle();
    check("t3.hit_live", 32'(PendingHit1), 1);
    check_port("t3.pipe", 1'b1, 5'd7, 32'hBBBB);
    tick();
    RegWriteW = 1'b0; settle();
    check("t3.hit_killed", 32'(PendingHit1), 0);
    check_port("t3.dead_pop", 1'b0, 5'd0, 32'h0);
    tick();

    // Long result to x0: accepted, not enqueued, never written.
    LongValid = 1'b1; LongAddress = 5'd0; LongData = 32'h99; ReadAddr1 = 5'd0;
    settle();
    check("t4.ready_x0", 32'(LongReady), 1);
    check("t4.hit_x0",   32'(PendingHit1), 0);
    check_port("t4.x0", 1'b0, 5'd0, 32'h0);
    tick();
    LongValid = 1'b0; settle();
    check_port("t4.x0_after", 1'b0, 5'd0, 32'h0);

    // Pipeline write to x0 is an idle slot: buffered x9 drains.
    RegWriteW = 1'b1; WriteAddressW = 5'd1; ResultW = 32'h11;
    LongValid = 1'b1; LongAddress = 5'd9; LongData = 32'h9999; ReadAddr2 = 5'd9;
    settle();
    check("t5.hit2_hs", 32'(PendingHit2), 1);
    tick();
    LongValid = 1'b0; WriteAddressW = 5'd0; ReadAddr1 = 5'd9; settle();
    check("t5.hit1_live", 32'(PendingHit1), 1);
    check_port("t5.drain_x0slot", 1'b1, 5'd9, 32'h9999);
    tick();
    check("t5.hit1_cleared", 32'(PendingHit1), 0);
    check_port("t5.empty", 1'b0, 5'd0, 32'h0);

    // Reset mid-drain with three entries buffered.
    WriteAddressW = 5'd1; ReadAddr1 = 5'd21;
    for (int i = 0; i < 3; i++) begin
      LongValid = 1'b1; LongAddress = 5'(20 + i); LongData = 32'hC0 + 32'(i);
      settle();
      tick();
    end
    LongValid = 1'b0; RegWriteW = 1'b0; settle();
    check_port("t6.drain", 1'b1, 5'd20, 32'hC0);
    check("t6.hit_pre", 32'(PendingHit1), 1);
    rst_n = 1'b0; RegWriteW = 1'b1; WriteAddressW = 5'd3; settle();
    check("t6.rst_we",    32'(RegWriteD),   0);
    check("t6.rst_ready", 32'(LongReady),   0);
    check("t6.rst_hit",   32'(PendingHit1), 0);
    check("t6.rst_stall", 32'(StallW),      0);
    tick();
    tick();
    rst_n = 1'b1; RegWriteW = 1'b0; settle();
    check("t6.rel_ready", 32'(LongReady),   1);
    check("t6.rel_hit",   32'(PendingHit1), 0);
    check_port("t6.rel_empty", 1'b0, 5'd0, 32'h0);
    tick();
    check_port("t6.still_empty", 1'b0, 5'd0, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
